// File: rtl/sramgen_sram_model_v2.sv
// Parametrised single-port SRAM model: lane write mask, chip enable, 1/2-cycle read
// latency, selectable read-during-write result and a post-reset zeroing sweep.
module sramgen_sram_model_v2 #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 11,
   parameter int WMASK_WIDTH    = 4,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ce,
   input  logic                   we,
   input  logic [WMASK_WIDTH-1:0] wmask,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0]  din,
   output logic [DATA_WIDTH-1:0]  dout,
   output logic                   dout_valid,
   output logic                   busy
);

   localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
   localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

   if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
      $error("DATA_WIDTH must be a multiple of WMASK_WIDTH");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("READ_LATENCY must be 1 or 2");
   end

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   cnt;
   logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   merged;
   logic                    accept;
   logic                    res_load, res_dv;
   logic [DATA_WIDTH-1:0]   res_data;
   logic                    fin_load, fin_dv;
   logic [DATA_WIDTH-1:0]   fin_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (cnt == '1) state_nxt = IDLE;
         default: state_nxt = state;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      if (state == CLEAR) busy = 1'b1;
   end

   assign accept  = ce & ~busy;
   assign rd_word = mem[addr];

   always_comb begin
      merged = rd_word;
      for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
         if (wmask[i]) merged[i*LANE_WIDTH +: LANE_WIDTH] = din[i*LANE_WIDTH +: LANE_WIDTH];
      end
   end

   // Memory is deliberately not reset; the reset branch only blocks writes.
   always_ff @(posedge clk or posedge rst) begin
      if (!rst) begin
         if (busy)              mem[cnt]  <= '0;
         else if (accept && we) mem[addr] <= merged;
      end
   end

   // Every accepted access occupies a result slot; only reads (and RDW mode 1 writes) are valid.
   always_comb begin
      res_load = accept;
      res_dv   = 1'b0;
      res_data = rd_word;
      if (accept) begin
         if (!we) begin
            res_dv = 1'b1;
         end else if (RDW_MODE != 0) begin
            res_dv   = 1'b1;
            res_data = merged;
         end else begin
            res_data = 'x;
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  p_load, p_dv;
      logic [DATA_WIDTH-1:0] p_data;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            p_load <= 1'b0;
            p_dv   <= 1'b0;
            p_data <= '0;
         end else begin
            p_load <= res_load;
            p_dv   <= res_dv;
            p_data <= res_data;
         end
      end

      assign fin_load = p_load;
      assign fin_dv   = p_dv;
      assign fin_data = p_data;
   end else begin : g_lat1
      assign fin_load = res_load;
      assign fin_dv   = res_dv;
      assign fin_data = res_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= fin_load & fin_dv;
         if (fin_load) dout <= fin_data;
      end
   end

endmodule
